// File: rtl/axi_sram_pkg.sv
// Shared widths and response codes for the AXI-to-SRAM-controller FIFO front-end.
// Width helpers let the top re-derive packed FIFO widths from its own parameters.
package axi_sram_pkg;

    localparam int A_DEF = 32;
    localparam int I_DEF = 4;
    localparam int L_DEF = 4;
    localparam int D_DEF = 512;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int ax_width(int i, int a, int l);
        return i + a + l + 5;
    endfunction

    function automatic int wd_width(int i, int d);
        return i + d + 1 + d / 8;
    endfunction

    function automatic int b_width(int i);
        return i + 2;
    endfunction

    function automatic int rd_width(int i, int d);
        return i + d + 1 + 2;
    endfunction

    localparam int W_AWFIFO = ax_width(I_DEF, A_DEF, L_DEF);
    localparam int W_WDFIFO = wd_width(I_DEF, D_DEF);
    localparam int W_BFIFO  = b_width(I_DEF);
    localparam int W_ARFIFO = ax_width(I_DEF, A_DEF, L_DEF);
    localparam int W_RDFIFO = rd_width(I_DEF, D_DEF);

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout while !empty.
// err flags a rejected push (full) or pop (empty) in the current cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] di,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign err     = (push && full) || (pop && empty);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= di;
    end

endmodule

// File: rtl/axi_sram_fifo_if.sv
// AXI3 slave front-end: one FWFT FIFO per channel, packed towards the SRAM controller.
// ovf_err latches any controller-side push-to-full or pop-from-empty until reset.
module axi_sram_fifo_if
    import axi_sram_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int I  = I_DEF,
    parameter int L  = L_DEF,
    parameter int D  = D_DEF,
    parameter int DA = 4,
    parameter int DD = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [I-1:0]                 s_awid,
    input  logic [A-1:0]                 s_awaddr,
    input  logic [L-1:0]                 s_awlen,
    input  logic [2:0]                   s_awsize,
    input  logic [1:0]                   s_awburst,
    input  logic                         s_awvalid,
    output logic                         s_awready,
    input  logic [I-1:0]                 s_wid,
    input  logic [D-1:0]                 s_wdata,
    input  logic [D/8-1:0]               s_wstrb,
    input  logic                         s_wlast,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    output logic [I-1:0]                 s_bid,
    output logic [1:0]                   s_bresp,
    output logic                         s_bvalid,
    input  logic                         s_bready,
    input  logic [I-1:0]                 s_arid,
    input  logic [A-1:0]                 s_araddr,
    input  logic [L-1:0]                 s_arlen,
    input  logic [2:0]                   s_arsize,
    input  logic [1:0]                   s_arburst,
    input  logic                         s_arvalid,
    output logic                         s_arready,
    output logic [I-1:0]                 s_rid,
    output logic [D-1:0]                 s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rlast,
    output logic                         s_rvalid,
    input  logic                         s_rready,
    input  logic                         awfifo_pop,
    output logic [ax_width(I,A,L)-1:0]   awfifo_do,
    output logic                         awfifo_empty,
    input  logic                         wdfifo_pop,
    output logic [wd_width(I,D)-1:0]     wdfifo_do,
    output logic                         wdfifo_empty,
    input  logic                         bfifo_push,
    input  logic [b_width(I)-1:0]        bfifo_di,
    output logic                         bfifo_full,
    input  logic                         arfifo_pop,
    output logic [ax_width(I,A,L)-1:0]   arfifo_do,
    output logic                         arfifo_empty,
    input  logic                         rdfifo_push,
    input  logic [rd_width(I,D)-1:0]     rdfifo_di,
    output logic                         rdfifo_full,
    output logic                         ovf_err
);

    localparam int WAX = ax_width(I, A, L);
    localparam int WWD = wd_width(I, D);
    localparam int WB  = b_width(I);
    localparam int WRD = rd_width(I, D);

    logic           aw_full, w_full, ar_full, b_empty, r_empty;
    logic [WB-1:0]  b_do;
    logic [WRD-1:0] r_do;
    logic [4:0]     err;

    assign s_awready = !aw_full && !rst;
    assign s_wready  = !w_full && !rst;
    assign s_arready = !ar_full && !rst;
    assign s_bvalid  = !b_empty;
    assign s_rvalid  = !r_empty;

    assign {s_bid, s_bresp}                  = b_do;
    assign {s_rid, s_rlast, s_rresp, s_rdata} = r_do;

    sync_fifo_fwft #(.WIDTH(WAX), .DEPTH(DA)) u_aw (
        .clk(clk), .rst(rst),
        .push(s_awvalid && s_awready),
        .di({s_awid, s_awlen, s_awsize, s_awburst, s_awaddr}),
        .full(aw_full), .pop(awfifo_pop), .dout(awfifo_do),
        .empty(awfifo_empty), .err(err[0])
    );

    sync_fifo_fwft #(.WIDTH(WWD), .DEPTH(DD)) u_w (
        .clk(clk), .rst(rst),
        .push(s_wvalid && s_wready),
        .di({s_wid, s_wstrb, s_wlast, s_wdata}),
        .full(w_full), .pop(wdfifo_pop), .dout(wdfifo_do),
        .empty(wdfifo_empty), .err(err[1])
    );

    sync_fifo_fwft #(.WIDTH(WAX), .DEPTH(DA)) u_ar (
        .clk(clk), .rst(rst),
        .push(s_arvalid && s_arready),
        .di({s_arid, s_arlen, s_arsize, s_arburst, s_araddr}),
        .full(ar_full), .pop(arfifo_pop), .dout(arfifo_do),
        .empty(arfifo_empty), .err(err[2])
    );

    sync_fifo_fwft #(.WIDTH(WB), .DEPTH(DA)) u_b (
        .clk(clk), .rst(rst),
        .push(bfifo_push), .di(bfifo_di), .full(bfifo_full),
        .pop(s_bvalid && s_bready), .dout(b_do),
        .empty(b_empty), .err(err[3])
    );

    sync_fifo_fwft #(.WIDTH(WRD), .DEPTH(DD)) u_r (
        .clk(clk), .rst(rst),
        .push(rdfifo_push), .di(rdfifo_di), .full(rdfifo_full),
        .pop(s_rvalid && s_rready), .dout(r_do),
        .empty(r_empty), .err(err[4])
    );

    // AXI-side handshakes are gated by ready/valid, so only controller-side misuse can raise err.
    always_ff @(posedge clk) begin
        if (rst)       ovf_err <= 1'b0;
        else if (|err) ovf_err <= 1'b1;
    end

endmodule
